// File: rtl/latch_mon_pkg.sv
// Shared types and default constants for the latch level monitor.
// The filter state type is only referenced when LATCH_MON_GLITCH_FILTER_EN is defined.
package latch_mon_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILTER_LEN  = 3;

    // STABLE: q_sync agrees with the synchronized input.
    // CANDIDATE: a differing level is being timed before it is accepted.
    typedef enum logic [0:0] {
        STABLE    = 1'b0,
        CANDIDATE = 1'b1
    } filt_state_e;

endpackage

// File: rtl/latch_sync.sv
// Multi-flop synchronizer that brings an asynchronous level into the clk domain.
// STAGES must be at least 2.
module latch_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous level through the flop chain; all stages clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of the stage before it.
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/latch_q_monitor.sv
// Latch level monitor: synchronizes the Q output of an upstream D latch, emits
// rise/fall pulses on accepted transitions, and counts them with a sticky wrap flag.
// Optional glitch filter: define LATCH_MON_GLITCH_FILTER_EN to require FILTER_LEN
// consecutive cycles of a new level before q_sync follows it.
module latch_q_monitor
    import latch_mon_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Q_in,
    input  logic             clr,
    output logic             q_sync,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_ovf
);

    // Reject illegal configurations at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("latch_q_monitor: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("latch_q_monitor: FILTER_LEN must be >= 1");
    end

    logic s_q;       // last synchronizer stage
    logic q_sync_d;  // level q_sync takes at the next edge

    latch_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Q_in),
        .q     (s_q)
    );

`ifdef LATCH_MON_GLITCH_FILTER_EN
    localparam int RUN_W = $clog2(FILTER_LEN + 1);

    filt_state_e        state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               toggle;

    // Filter state register: reset discards any partially timed candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Filter next-state: time how long s_q has disagreed with q_sync.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        state_d = state_q;
        run_d   = run_q;
        toggle  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (s_q != q_sync) begin
                    if (FILTER_LEN == 1) begin
                        toggle = 1'b1;
                    end else begin
                        state_d = CANDIDATE;
                        run_d   = RUN_W'(1);
                    end
                end
            end
            CANDIDATE: begin
                if (s_q == q_sync) begin
                    state_d = STABLE;
                    run_d   = '0;
                end else if (run_q + RUN_W'(1) == RUN_W'(FILTER_LEN)) begin
                    toggle  = 1'b1;
                    state_d = STABLE;
                    run_d   = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                run_d   = '0;
            end
        endcase
    end

    // Filter output: q_sync flips only when a candidate has lasted FILTER_LEN cycles.
    always_comb begin
        q_sync_d = q_sync ^ toggle;
    end
`else
    // Unfiltered: q_sync is s_q delayed by one more flop.
    always_comb begin
        q_sync_d = s_q;
    end
`endif

    // Output register: q_sync and the edge pulses are aligned to the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            q_sync <= q_sync_d;
            rise   <= q_sync_d & ~q_sync;
            fall   <= ~q_sync_d & q_sync;
        end
    end

    // Edge counter with sticky wrap flag; clr wins over a coincident pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            cnt_ovf  <= 1'b0;
        end else if (clr) begin
            edge_cnt <= '0;
            cnt_ovf  <= 1'b0;
        end else if (rise || fall) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
            if (&edge_cnt) begin
                cnt_ovf <= 1'b1;
            end
        end
    end

endmodule
